spi_master_param: RTL

//  Parametrised SPI master: shifts one DATA_W-bit word out on MOSI while capturing DATA_W bits from MISO.

---
 rtl/spi_master_param.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master.
// Shifts one DATA_W-bit word out on MOSI while capturing DATA_W bits from MISO.
// Supports all four CPOL/CPHA modes, a fixed SCLK divider and 2**CS_SEL_W chip selects.
// Optional feature macro SPI_MASTER_LSB_FIRST_EN adds input lsb_first_i, which
// selects LSB-first transmission and LSB-first assembly of rx_data_o.
// Without the macro the port is absent and transfers are always MSB-first.
module spi_master_param #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SEL_W = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [DATA_W-1:0]         tx_data_i,
  input  logic                      cpol_i,
  input  logic                      cpha_i,
  input  logic [CS_SEL_W-1:0]       cs_sel_i,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                      lsb_first_i,
`endif
  input  logic                      spi_miso_i,
  output logic                      spi_sclk_o,
  output logic                      spi_mosi_o,
  output logic [(2**CS_SEL_W)-1:0]  spi_cs_n_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DATA_W-1:0]         rx_data_o
);

  localparam int NUM_CS = 2**CS_SEL_W;
  localparam int HALF_W = $clog2(DATA_W) + 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [NUM_CS-1:0] CS_ONE    = {{(NUM_CS-1){1'b0}}, 1'b1};
  localparam logic [NUM_CS-1:0] CS_IDLE   = {NUM_CS{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_q, rx_d;

  logic                edge_s;
  logic                div_end_s;
  logic                lsb_in_s;
  logic [HALF_W-1:0]   half_nxt_s;
  logic [HALF_W-1:0]   bit_idx_s;

  // Bit idx of word w in transmit order (idx 0 is sent first).
  function automatic logic tx_bit(input logic [DATA_W-1:0] w,
                                  input logic [HALF_W-1:0] idx,
                                  input logic              lsb);
    logic [DATA_W-1:0] sh;
    if (lsb) begin
      sh = w >> idx;
      return sh[0];
    end else begin
      sh = w << idx;
      return sh[DATA_W-1];
    end
  endfunction

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in_s = lsb_first_i;
`else
  assign lsb_in_s = 1'b0;
`endif

  // Next-state logic: FSM sequencing, divider/half-period counting, shifting.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    tx_d       = tx_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    rx_sh_d    = rx_sh_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    rx_d       = rx_q;
    edge_s     = 1'b0;
    half_nxt_s = {HALF_W{1'b0}};
    div_end_s  = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        cs_n_d = CS_IDLE;
        sclk_d = cpol_q;
        div_d  = {DIV_W{1'b0}};
        if (start_i) begin
          // Latch the whole transfer configuration; inputs are ignored until IDLE again.
          tx_d    = tx_data_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          lsb_d   = lsb_in_s;
          state_d = ST_SETUP;
          cs_n_d  = ~(CS_ONE << cs_sel_i);
          sclk_d  = cpol_i;
          mosi_d  = tx_bit(tx_data_i, {HALF_W{1'b0}}, lsb_in_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_end_s) begin
          div_d   = {DIV_W{1'b0}};
          half_d  = {HALF_W{1'b0}};
          state_d = ST_XFER;
          edge_s  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1'b1);
        end
      end
      ST_XFER: begin
        if (div_end_s) begin
          div_d = {DIV_W{1'b0}};
          if (half_q == HALF_LAST) begin
            // sclk is already back at cpol after an even number of edges.
            state_d = ST_HOLD;
          end else begin
            half_d     = half_q + HALF_W'(1'b1);
            half_nxt_s = half_q + HALF_W'(1'b1);
            edge_s     = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1'b1);
        end
      end
      ST_HOLD: begin
        if (div_end_s) begin
          div_d   = {DIV_W{1'b0}};
          state_d = ST_IDLE;
          cs_n_d  = CS_IDLE;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end else begin
          div_d = div_q + DIV_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = CS_IDLE;
        div_d   = {DIV_W{1'b0}};
      end
    endcase

    // Edge k opens half-period k; even k are leading edges, odd k trailing.
    // cpha=0 shifts on trailing edges (bit (k+1)/2), cpha=1 on leading (bit k/2).
    bit_idx_s = (half_nxt_s >> 1) + {{(HALF_W-1){1'b0}}, ~cpha_q};
    if (edge_s) begin
      sclk_d = ~sclk_q;
      if (half_nxt_s[0] == cpha_q) begin
        if (lsb_q) begin
          rx_sh_d = {spi_miso_i, rx_sh_q[DATA_W-1:1]};
        end else begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso_i};
        end
      end else if (half_nxt_s != HALF_LAST) begin
        mosi_d = tx_bit(tx_q, bit_idx_s, lsb_q);
      end else begin
        mosi_d = mosi_q;
      end
    end else begin
      rx_sh_d = rx_sh_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= {DIV_W{1'b0}};
      half_q  <= {HALF_W{1'b0}};
      tx_q    <= {DATA_W{1'b0}};
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      rx_sh_q <= {DATA_W{1'b0}};
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= CS_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      rx_sh_q <= rx_sh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rx_data_o  = rx_q;

endmodule
